// File: rtl/ssb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssb_timer_pkg
// Description : Shared types, symbol-index constants and helpers for the
//               SS-block symbol timer.
// Revision    : 1.0 - initial release
// ============================================================================
package ssb_timer_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        SKIP_CP = 2'd1,
        SYMBOL  = 2'd2
    } state_t;

    localparam logic [2:0] SYM_PBCH1 = 3'd1;
    localparam logic [2:0] SYM_SSS   = 3'd2;
    localparam logic [2:0] SYM_PBCH2 = 3'd3;

    // Lowest asserted bit wins so simultaneous peaks resolve deterministically.
    function automatic logic [1:0] lowest_set_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage : ssb_timer_pkg
`default_nettype wire

// File: rtl/ssb_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module      : ssb_symbol_timer
// Description : Tracks the SS-block symbols after a PSS peak in valid-sample
//               time, skipping cyclic prefixes and strobing the FFT/demod.
// Revision    : 1.0 - initial release
// ============================================================================
module ssb_symbol_timer
    import ssb_timer_pkg::*;
#(
    parameter int NFFT_LOG2       = 8,
    parameter int CP_LEN          = 18,
    parameter int DETECTION_DELAY = 15,
    parameter int N_CH            = 3,
    parameter int NUM_SYMBOLS     = 3
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            s_axis_in_tvalid,
    input  logic [N_CH-1:0] peak_detected_i,
    input  logic            search_en_i,
    output logic            fft_ce_o,
    output logic            symbol_start_o,
    output logic [2:0]      symbol_idx_o,
    output logic            pbch_start_o,
    output logic            sss_start_o,
    output logic [1:0]      N_id_2_o,
    output logic            N_id_2_valid_o,
    output logic            busy_o,
    output logic            ssb_done_o
);

    localparam int c_nfft    = 1 << NFFT_LOG2;
    localparam int c_cp_bits = $clog2(CP_LEN + 1);
    localparam int c_cnt_w   = (NFFT_LOG2 > c_cp_bits) ? NFFT_LOG2 : c_cp_bits;

    localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_last_samp  = c_cnt_w'(c_nfft - 1);
    localparam logic [c_cnt_w-1:0] c_first_skip = c_cnt_w'(CP_LEN - DETECTION_DELAY);
    localparam logic [c_cnt_w-1:0] c_cp_skip    = c_cnt_w'(CP_LEN);
    localparam logic [2:0]         c_num_sym    = 3'(NUM_SYMBOLS);

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   skip_q, skip_d;
    logic [c_cnt_w-1:0]   samp_q, samp_d;
    logic [2:0]           idx_q, idx_d;
    logic [1:0]           nid_q, nid_d;
    logic                 nid_valid_q, nid_valid_d;
    logic                 done_q, done_d;

    logic [3:0]           w_peak_ext;
    logic                 w_trigger;
    logic                 w_sym_start;

    always_comb begin
        w_peak_ext               = 4'd0;
        w_peak_ext[N_CH-1:0]     = peak_detected_i;
    end

    assign w_trigger = search_en_i && s_axis_in_tvalid && (|peak_detected_i);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= SEARCH;
            skip_q      <= '0;
            samp_q      <= '0;
            idx_q       <= 3'd0;
            nid_q       <= 2'd0;
            nid_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            samp_q      <= samp_d;
            idx_q       <= idx_d;
            nid_q       <= nid_d;
            nid_valid_q <= nid_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        samp_d      = samp_q;
        idx_d       = idx_q;
        nid_d       = nid_q;
        nid_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            SEARCH: begin
                if (w_trigger) begin
                    // Part of the first CP already elapsed inside the detector.
                    state_d     = SKIP_CP;
                    skip_d      = c_first_skip;
                    samp_d      = '0;
                    nid_d       = lowest_set_idx(w_peak_ext);
                    nid_valid_d = 1'b1;
                    idx_d       = SYM_PBCH1;
                end
            end
            SKIP_CP: begin
                if (s_axis_in_tvalid) begin
                    skip_d = skip_q - c_one;
                    if (skip_q == c_one) begin
                        state_d = SYMBOL;
                    end
                end
            end
            SYMBOL: begin
                if (s_axis_in_tvalid) begin
                    if (samp_q == c_last_samp) begin
                        samp_d = '0;
                        if (idx_q < c_num_sym) begin
                            idx_d   = idx_q + 3'd1;
                            state_d = SKIP_CP;
                            skip_d  = c_cp_skip;
                        end else begin
                            idx_d   = 3'd0;
                            state_d = SEARCH;
                            done_d  = 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + c_one;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    assign w_sym_start = (state_q == SYMBOL) && s_axis_in_tvalid && (samp_q == '0);

    always_comb begin
        fft_ce_o       = (state_q == SYMBOL) && s_axis_in_tvalid;
        symbol_start_o = w_sym_start;
        pbch_start_o   = w_sym_start && ((idx_q == SYM_PBCH1) || (idx_q == SYM_PBCH2));
        sss_start_o    = w_sym_start && (idx_q == SYM_SSS);
        busy_o         = (state_q != SEARCH);
    end

    assign symbol_idx_o   = idx_q;
    assign N_id_2_o       = nid_q;
    assign N_id_2_valid_o = nid_valid_q;
    assign ssb_done_o     = done_q;

endmodule : ssb_symbol_timer
`default_nettype wire

// File: tb/tb_ssb_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssb_symbol_timer
// Description : Randomised scoreboard bench for ssb_symbol_timer against a
//               sample-offset reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssb_symbol_timer;

    localparam int NFFT_LOG2       = 8;
    localparam int NFFT            = 1 << NFFT_LOG2;
    localparam int CP_LEN          = 18;
    localparam int DETECTION_DELAY = 15;
    localparam int N_CH            = 3;
    localparam int NUM_SYMBOLS     = 3;

    typedef struct packed {
        logic       fft;
        logic       start;
        logic       pbch;
        logic       sss;
        logic       nidv;
        logic       busy;
        logic       done;
        logic [2:0] idx;
        logic [1:0] nid;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            reset_ni;
    logic            s_axis_in_tvalid;
    logic [N_CH-1:0] peak_detected_i;
    logic            search_en_i;
    logic            fft_ce_o;
    logic            symbol_start_o;
    logic [2:0]      symbol_idx_o;
    logic            pbch_start_o;
    logic            sss_start_o;
    logic [1:0]      N_id_2_o;
    logic            N_id_2_valid_o;
    logic            busy_o;
    logic            ssb_done_o;

    int   checks = 0;
    int   errors = 0;
    int   dut_fft_cnt = 0;
    exp_t exp_q[$];

    // Reference model state: block activity and valid-sample offset since peak.
    bit       m_active = 0;
    int       m_off    = 0;
    bit [1:0] m_nid    = 0;
    bit       m_nidv   = 0;
    bit       m_done   = 0;
    bit [2:0] m_idx    = 0;

    ssb_symbol_timer #(
        .NFFT_LOG2       (NFFT_LOG2),
        .CP_LEN          (CP_LEN),
        .DETECTION_DELAY (DETECTION_DELAY),
        .N_CH            (N_CH),
        .NUM_SYMBOLS     (NUM_SYMBOLS)
    ) dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .s_axis_in_tvalid (s_axis_in_tvalid),
        .peak_detected_i  (peak_detected_i),
        .search_en_i      (search_en_i),
        .fft_ce_o         (fft_ce_o),
        .symbol_start_o   (symbol_start_o),
        .symbol_idx_o     (symbol_idx_o),
        .pbch_start_o     (pbch_start_o),
        .sss_start_o      (sss_start_o),
        .N_id_2_o         (N_id_2_o),
        .N_id_2_valid_o   (N_id_2_valid_o),
        .busy_o           (busy_o),
        .ssb_done_o       (ssb_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Offset (in valid samples after the peak) of the first FFT sample of symbol s.
    function automatic int sym_first(input int s);
        return CP_LEN - DETECTION_DELAY + 1 + (s - 1) * (NFFT + CP_LEN);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit v, input bit [N_CH-1:0] pk, input bit se, input bit rn);
        exp_t e;
        int   o;
        @(negedge clk_i);
        s_axis_in_tvalid = v;
        peak_detected_i  = pk;
        search_en_i      = se;
        reset_ni         = rn;
        e = '0;
        if (!rn) begin
            m_active = 0; m_off = 0; m_nid = 0; m_nidv = 0; m_done = 0; m_idx = 0;
            exp_q.push_back(e);
            return;
        end
        e.busy = m_active;
        e.nid  = m_nid;
        e.nidv = m_nidv;
        e.done = m_done;
        e.idx  = m_idx;
        m_nidv = 0;
        m_done = 0;
        if (m_active && v) begin
            o = m_off;
            for (int s = 1; s <= NUM_SYMBOLS; s++) begin
                if (o >= sym_first(s) && o < sym_first(s) + NFFT) begin
                    e.fft   = 1'b1;
                    e.start = (o == sym_first(s));
                    e.pbch  = e.start && (s == 1 || s == 3);
                    e.sss   = e.start && (s == 2);
                    if (o == sym_first(s) + NFFT - 1) begin
                        if (s == NUM_SYMBOLS) begin
                            m_active = 0;
                            m_done   = 1;
                            m_idx    = 0;
                        end else begin
                            m_idx = 3'(s + 1);
                        end
                    end
                end
            end
            m_off++;
        end else if (!m_active && se && v && pk != 0) begin
            for (int b = N_CH - 1; b >= 0; b--) begin
                if (pk[b]) m_nid = 2'(b);
            end
            m_active = 1;
            m_off    = 1;
            m_nidv   = 1;
            m_idx    = 1;
        end
        exp_q.push_back(e);
    endtask

    // tv_mode: 0 continuous, 1 every 2nd cycle, 2 random; se_mode: 0 low, 1 high, 2 random.
    task automatic run_until_idle(input int tv_mode, input bit rand_peaks, input int se_mode);
        int          n;
        bit          v;
        bit          se;
        bit [N_CH-1:0] pk;
        n = 0;
        while (m_active) begin
            if (n > 4000) begin
                check("block_timeout", n, 4000);
                return;
            end
            case (tv_mode)
                0:       v = 1'b1;
                1:       v = (n % 2 == 1);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            case (se_mode)
                0:       se = 1'b0;
                1:       se = 1'b1;
                default: se = $urandom_range(0, 1) == 1;
            endcase
            pk = '0;
            if (rand_peaks && $urandom_range(0, 7) == 0)
                pk = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            step(v, pk, se, 1'b1);
            n++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (fft_ce_o) dut_fft_cnt++;
                check("fft_ce",       fft_ce_o,       e.fft);
                check("symbol_start", symbol_start_o, e.start);
                check("pbch_start",   pbch_start_o,   e.pbch);
                check("sss_start",    sss_start_o,    e.sss);
                check("nid_valid",    N_id_2_valid_o, e.nidv);
                check("busy",         busy_o,         e.busy);
                check("ssb_done",     ssb_done_o,     e.done);
                check("symbol_idx",   symbol_idx_o,   e.idx);
                check("N_id_2",       N_id_2_o,       e.nid);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        reset_ni = 1'b0; s_axis_in_tvalid = 1'b0; peak_detected_i = '0; search_en_i = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b1, 1'b0);
        idle(3);

        // Peak on ch1, continuous tvalid, stray peaks while busy.
        dut_fft_cnt = 0;
        step(1'b1, 3'b010, 1'b1, 1'b1);
        run_until_idle(0, 1'b1, 1);
        idle(3);
        check("fft_ce_total", dut_fft_cnt, 768);

        // Simultaneous peaks resolve to the lowest index.
        step(1'b1, 3'b110, 1'b1, 1'b1);
        run_until_idle(0, 1'b0, 1);
        idle(2);

        // tvalid every second cycle.
        step(1'b1, 3'b001, 1'b1, 1'b1);
        run_until_idle(1, 1'b1, 1);
        idle(2);

        // search_en low ignores peaks; deasserting it mid-block does not abort.
        for (int i = 0; i < 5; i++) step(1'b1, 3'b001, 1'b0, 1'b1);
        step(1'b1, 3'b100, 1'b1, 1'b1);
        run_until_idle(0, 1'b1, 0);
        idle(2);

        // Reset in the middle of the SSS symbol, then restart from symbol 1.
        step(1'b1, 3'b100, 1'b1, 1'b1);
        for (int i = 0; i < 2000 && !(m_idx == 2 && m_off > sym_first(2) + 10); i++)
            step(1'b1, '0, 1'b1, 1'b1);
        step(1'b1, '0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 3'b011, 1'b1, 1'b1);
        run_until_idle(0, 1'b0, 1);
        idle(2);

        // Random tvalid gaps, channels and search_en.
        for (int b = 0; b < 3; b++) begin
            step(1'b1, N_CH'($urandom_range(1, (1 << N_CH) - 1)), 1'b1, 1'b1);
            run_until_idle(2, 1'b1, 2);
            idle(2);
        end

        @(negedge clk_i);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ssb_symbol_timer
`default_nettype wire
